// File: rtl/router_register_p.sv
// rtl/router_register_p.sv - router packet register stage with hold buffer and packet checks
module router_register_p #(
    parameter int DW         = 8,
    parameter int ADDR_W     = 2,
    parameter int NUM_CH     = 3,
    parameter int HOLD_DEPTH = 2,
    parameter int CHK_MODE   = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                pkt_vld,
    input  logic                                fifo_full,
    input  logic                                detect_add,
    input  logic                                lfd_state,
    input  logic                                ld_state,
    input  logic                                laf_state,
    input  logic                                full_state,
    input  logic                                rst_int_reg,
    input  logic [DW-1:0]                       data_in,
    output logic [DW-1:0]                       data_out,
    output logic                                data_out_vld,
    output logic [$clog2(HOLD_DEPTH+1)-1:0]     hold_cnt,
    output logic                                hold_empty,
    output logic                                hold_full,
    output logic                                low_pkt_vld,
    output logic                                parity_done,
    output logic                                error,
    output logic                                len_err,
    output logic                                addr_err,
    output logic                                ovf_err
);

    localparam int PW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
    localparam int LW = DW - ADDR_W;
    localparam int CW = $clog2(HOLD_DEPTH + 1);
    localparam logic [31:0] NUM_CH_U = NUM_CH;

    logic [DW-1:0] hhb;
    logic [DW-1:0] int_chk;
    logic [DW-1:0] pkt_chk;
    logic [LW-1:0] byte_cnt;
    logic [DW-1:0] hold_mem [HOLD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic addr_ok;
    logic ld_act;
    logic laf_act;
    logic fwd;
    logic push;
    logic drop;
    logic pop;

    function automatic logic [DW-1:0] chk_f(input logic [DW-1:0] acc, input logic [DW-1:0] b);
        return (CHK_MODE == 1) ? acc + b : acc ^ b;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(HOLD_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign hold_empty = (hold_cnt == '0);
    assign hold_full  = (hold_cnt == CW'(HOLD_DEPTH));
    assign addr_ok    = (32'(data_in[ADDR_W-1:0]) < NUM_CH_U);

    // full_state freezes the datapath; ld/laf only act when no higher-priority strobe is up
    assign ld_act  = !detect_add && !lfd_state && ld_state && !full_state;
    assign laf_act = !detect_add && !lfd_state && !ld_state && laf_state && !full_state;
    // once anything is held, new bytes queue behind it so FIFO order is preserved
    assign fwd     = ld_act && !fifo_full && hold_empty;
    assign push    = ld_act && !fwd && !hold_full;
    assign drop    = ld_act && !fwd && hold_full;
    assign pop     = laf_act && !fifo_full && !hold_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out     <= '0;
            data_out_vld <= 1'b0;
            hold_cnt     <= '0;
            low_pkt_vld  <= 1'b0;
            parity_done  <= 1'b0;
            error        <= 1'b0;
            len_err      <= 1'b0;
            addr_err     <= 1'b0;
            ovf_err      <= 1'b0;
            hhb          <= '0;
            int_chk      <= '0;
            pkt_chk      <= '0;
            byte_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            for (int i = 0; i < HOLD_DEPTH; i++) hold_mem[i] <= '0;
        end else begin
            data_out_vld <= 1'b0;
            error        <= parity_done && (int_chk != pkt_chk);
            len_err      <= parity_done && (byte_cnt != hhb[DW-1:ADDR_W]);
            if (rst_int_reg) low_pkt_vld <= 1'b0;

            if (detect_add) begin
                if (pkt_vld) begin
                    int_chk     <= '0;
                    pkt_chk     <= '0;
                    byte_cnt    <= '0;
                    parity_done <= 1'b0;
                    len_err     <= 1'b0;
                    ovf_err     <= 1'b0;
                    if (addr_ok) begin
                        hhb      <= data_in;
                        addr_err <= 1'b0;
                    end else begin
                        addr_err <= 1'b1;
                    end
                end
            end else if (lfd_state) begin
                data_out     <= hhb;
                data_out_vld <= 1'b1;
                int_chk      <= chk_f(int_chk, hhb);
            end else if (ld_act) begin
                if (pkt_vld) begin
                    byte_cnt <= byte_cnt + LW'(1);
                    if (!drop) int_chk <= chk_f(int_chk, data_in);
                end else begin
                    pkt_chk     <= data_in;
                    low_pkt_vld <= 1'b1;
                    if (fwd) parity_done <= 1'b1;
                end
                if (fwd) begin
                    data_out     <= data_in;
                    data_out_vld <= 1'b1;
                end
                if (push) begin
                    hold_mem[wr_ptr] <= data_in;
                    wr_ptr           <= next_ptr(wr_ptr);
                    hold_cnt         <= hold_cnt + CW'(1);
                end
                if (drop) ovf_err <= 1'b1;
            end else if (laf_act) begin
                if (pop) begin
                    data_out     <= hold_mem[rd_ptr];
                    data_out_vld <= 1'b1;
                    rd_ptr       <= next_ptr(rd_ptr);
                    hold_cnt     <= hold_cnt - CW'(1);
                end else if (hold_empty && low_pkt_vld && !parity_done) begin
                    parity_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_register_p.sv
// tb/tb_router_register_p.sv - scoreboard bench for router_register_p (XOR and sum instances)
module tb_router_register_p;

    localparam int HD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       pkt_vld, fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0] data_in;

    logic [7:0] data_out, data_out_b;
    logic       data_out_vld, data_out_vld_b;
    logic [1:0] hold_cnt, hold_cnt_b;
    logic       hold_empty, hold_full, low_pkt_vld, parity_done, error, len_err, addr_err, ovf_err;
    logic       hold_empty_b, hold_full_b, low_pkt_vld_b, parity_done_b, error_b, len_err_b, addr_err_b, ovf_err_b;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb[$];
    logic [7:0] m_hhb, m_xor, m_sum, m_chk;
    logic [5:0] m_bcnt;
    int         m_cnt;

    always #5 clk = ~clk;

    router_register_p #(.DW(8), .ADDR_W(2), .NUM_CH(3), .HOLD_DEPTH(HD), .CHK_MODE(0)) dut (
        .clk(clk), .reset(reset), .pkt_vld(pkt_vld), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .data_in(data_in), .data_out(data_out), .data_out_vld(data_out_vld),
        .hold_cnt(hold_cnt), .hold_empty(hold_empty), .hold_full(hold_full),
        .low_pkt_vld(low_pkt_vld), .parity_done(parity_done), .error(error),
        .len_err(len_err), .addr_err(addr_err), .ovf_err(ovf_err)
    );

    router_register_p #(.DW(8), .ADDR_W(2), .NUM_CH(3), .HOLD_DEPTH(HD), .CHK_MODE(1)) dut_sum (
        .clk(clk), .reset(reset), .pkt_vld(pkt_vld), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .data_in(data_in), .data_out(data_out_b), .data_out_vld(data_out_vld_b),
        .hold_cnt(hold_cnt_b), .hold_empty(hold_empty_b), .hold_full(hold_full_b),
        .low_pkt_vld(low_pkt_vld_b), .parity_done(parity_done_b), .error(error_b),
        .len_err(len_err_b), .addr_err(addr_err_b), .ovf_err(ovf_err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && data_out_vld) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {24'd0, data_out}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] exp;
                exp = sb.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, exp});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pkt_vld = 0; fifo_full = 0; detect_add = 0; lfd_state = 0; ld_state = 0;
        laf_state = 0; full_state = 0; rst_int_reg = 0; data_in = 8'h00;
    endtask

    task automatic header(input logic [7:0] h);
        idle();
        detect_add = 1; pkt_vld = 1; data_in = h;
        if (h[1:0] < 2'd3) m_hhb = h;
        m_xor = 0; m_sum = 0; m_bcnt = 0;
        tick();
    endtask

    task automatic lfd();
        idle();
        lfd_state = 1;
        sb.push_back(m_hhb);
        m_xor = m_xor ^ m_hhb;
        m_sum = m_sum + m_hhb;
        tick();
    endtask

    task automatic ld(input logic [7:0] b, input logic ff, input logic is_chk);
        logic dropped;
        idle();
        ld_state = 1; pkt_vld = !is_chk; fifo_full = ff; data_in = b;
        dropped = 0;
        if (!ff && m_cnt == 0) sb.push_back(b);
        else if (m_cnt < HD) begin sb.push_back(b); m_cnt++; end
        else dropped = 1;
        if (is_chk) m_chk = b;
        else begin
            m_bcnt = m_bcnt + 6'd1;
            if (!dropped) begin m_xor = m_xor ^ b; m_sum = m_sum + b; end
        end
        tick();
    endtask

    task automatic laf(input logic ff);
        idle();
        laf_state = 1; fifo_full = ff;
        if (!ff && m_cnt > 0) m_cnt--;
        tick();
    endtask

    // parity_done has just risen: error lags by one cycle, then both results are checked
    task automatic check_result(input string tag);
        check({tag, "_pd"}, parity_done, 1);
        check({tag, "_err_lag"}, error, 0);
        idle();
        tick();
        check({tag, "_err"}, error, (m_xor != m_chk));
        check({tag, "_err_sum"}, error_b, (m_sum != m_chk));
        check({tag, "_len"}, len_err, (m_bcnt != m_hhb[7:2]));
        rst_int_reg = 1;
        tick();
        check({tag, "_lpv_clr"}, low_pkt_vld, 0);
        check({tag, "_pd_keep"}, parity_done, 1);
    endtask

    initial begin
        idle();
        m_hhb = 0; m_xor = 0; m_sum = 0; m_chk = 0; m_bcnt = 0; m_cnt = 0;
        reset = 1;
        tick();
        tick();
        check("rst_data_out", {24'd0, data_out}, 0);
        check("rst_vld", data_out_vld, 0);
        check("rst_cnt", hold_cnt, 0);
        check("rst_empty", hold_empty, 1);
        check("rst_flags", {low_pkt_vld, parity_done, error, len_err, addr_err, ovf_err, hold_full}, 0);
        reset = 0;

        // direct packet with a good XOR check byte
        header(8'h0D); lfd();
        ld(8'h11, 0, 0); ld(8'h22, 0, 0); ld(8'h33, 0, 0);
        ld(m_xor, 0, 1);
        check("p1_lpv", low_pkt_vld, 1);
        check_result("p1");

        // same packet with a corrupted check byte
        header(8'h0D); lfd();
        ld(8'h11, 0, 0); ld(8'h22, 0, 0); ld(8'h33, 0, 0);
        ld(8'h2C, 0, 1);
        check_result("p2");

        // hold buffer: fill, overflow, freeze, drain with pointer wrap
        header(8'h0D); lfd();
        ld(8'h11, 1, 0); ld(8'h22, 1, 0);
        check("hold_cnt2", hold_cnt, 2);
        check("hold_full", hold_full, 1);
        ld(8'h33, 1, 0);
        check("ovf_set", ovf_err, 1);
        check("ovf_cnt", hold_cnt, 2);
        idle(); full_state = 1; tick();
        check("frozen_cnt", hold_cnt, 2);
        laf(0);
        check("pop_cnt1", hold_cnt, 1);
        ld(m_xor, 0, 1);
        check("chk_pushed", hold_cnt, 2);
        check("chk_pd_low", parity_done, 0);
        laf(0); laf(0);
        check("drained", hold_empty, 1);
        check("drained_pd", parity_done, 0);
        laf(0);
        check_result("p3");
        check("ovf_sticky", ovf_err, 1);

        // short payload gives a length error; header clears overflow
        header(8'h0D);
        check("ovf_clr", ovf_err, 0);
        lfd(); ld(8'h11, 0, 0); ld(m_xor, 0, 1);
        check_result("p4");

        // illegal address keeps the old header byte
        header(8'h03);
        check("addr_set", addr_err, 1);
        lfd();
        header(8'h05);
        check("addr_clr", addr_err, 0);
        lfd();

        // sum mode reference packet: 0x09+0xF0+0x20 wraps to 0x19
        header(8'h09); lfd();
        ld(8'hF0, 0, 0); ld(8'h20, 0, 0); ld(8'h19, 0, 1);
        check("sum_model", {24'd0, m_sum}, 32'h19);
        check_result("p5");
        check("sum_ok", error_b, 0);
        check("xor_bad", error, 1);

        // reset mid-packet discards held data
        header(8'h0D); lfd();
        ld(8'h55, 1, 0);
        check("mid_cnt", hold_cnt, 1);
        idle(); reset = 1;
        sb.delete(); m_cnt = 0;
        tick();
        reset = 0;
        check("mid_rst_cnt", hold_cnt, 0);
        check("mid_rst_lpv", {low_pkt_vld, parity_done, data_out}, 0);
        idle(); tick(); tick();

        check("sb_left", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
